// File: rtl/adder_tree_arbiter.sv
// Purpose : shares one external combinational masked adder tree between two
//           requesters, locks it to the winner for a burst and returns one
//           tagged, saturated burst total.
// Latency : single-beat burst accepted at cycle N -> resp_valid at N+1;
//           a K-beat burst gives resp_valid one cycle after its last beat.
// Backpressure: req*_ready is low in HOLD until resp_valid & resp_ready, and
//           the non-owner is never granted during a burst.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   req{0,1}_valid/ready     beat handshake per requester
//   req{0,1}_data/mm/last    eight 4-bit lanes, lane mask, final-beat flag
//   tree_data/tree_mm        drive the external adder tree inputs
//   tree_result              combinational sum returned by the tree
//   resp_valid/ready         burst-total handshake
//   resp_id/sum/beats/sat    owner, saturated total, beat count, clip flag
module adder_tree_arbiter #(
    parameter int ACC_W  = 12,
    parameter int BEAT_W = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [31:0]       req0_data,
    input  logic [5:0]        req0_mm,
    input  logic              req0_last,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [31:0]       req1_data,
    input  logic [5:0]        req1_mm,
    input  logic              req1_last,

    output logic [31:0]       tree_data,
    output logic [5:0]        tree_mm,
    input  logic [6:0]        tree_result,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [ACC_W-1:0]  resp_sum,
    output logic [BEAT_W-1:0] resp_beats,
    output logic              resp_sat
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    // One extra bit on the running sum exposes the overflow as a carry.
    localparam int                SUM_W    = ACC_W + 1;
    localparam logic [ACC_W-1:0]  ACC_MAX  = {ACC_W{1'b1}};
    localparam logic [BEAT_W-1:0] BEAT_MAX = {BEAT_W{1'b1}};

    logic [1:0]        r_state;
    logic              r_rr_ptr;
    logic              r_owner;
    logic [ACC_W-1:0]  r_acc;
    logic [BEAT_W-1:0] r_beats;
    logic              r_sat;

    logic              w_idle;
    logic              w_burst;
    logic              w_hold;
    logic              w_grant_vld;
    logic              w_grant_id;
    logic              w_sel_vld;
    logic              w_sel_id;
    logic              w_sel_valid;
    logic [31:0]       w_sel_data;
    logic [5:0]        w_sel_mm;
    logic              w_sel_last;
    logic              w_accept;
    logic [SUM_W-1:0]  w_sum;
    logic              w_ovf;
    logic [ACC_W-1:0]  w_acc_next;

    assign w_idle  = (r_state == S_IDLE);
    assign w_burst = (r_state == S_BURST);
    assign w_hold  = (r_state == S_HOLD);

    // Round-robin pointer only matters when both requesters contend;
    // a lone valid always wins.
    always_comb begin
        w_grant_vld = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            w_grant_id = r_rr_ptr;
        end else begin
            w_grant_id = req1_valid;
        end
    end

    // The tree is offered to the IDLE winner or to the burst owner. While
    // reset is asserted nothing is selected, so every driven output reads 0.
    assign w_sel_vld = !rst && ((w_idle && w_grant_vld) || w_burst);
    assign w_sel_id  = w_idle ? w_grant_id : r_owner;

    always_comb begin
        if (w_sel_id) begin
            w_sel_valid = req1_valid;
            w_sel_data  = req1_data;
            w_sel_mm    = req1_mm;
            w_sel_last  = req1_last;
        end else begin
            w_sel_valid = req0_valid;
            w_sel_data  = req0_data;
            w_sel_mm    = req0_mm;
            w_sel_last  = req0_last;
        end
    end

    // Ready depends only on selection, never on the requester's own valid
    // in BURST, so an owner may stall for as long as it likes.
    assign req0_ready = w_sel_vld && !w_sel_id;
    assign req1_ready = w_sel_vld &&  w_sel_id;
    assign w_accept   = w_sel_vld && w_sel_valid;

    assign tree_data = w_sel_vld ? w_sel_data : 32'd0;
    assign tree_mm   = w_sel_vld ? w_sel_mm   : 6'd0;

    // Saturating accumulate: clip to all-ones and remember that we clipped.
    assign w_sum      = {1'b0, r_acc} + SUM_W'(tree_result);
    assign w_ovf      = w_sum[ACC_W];
    assign w_acc_next = w_ovf ? ACC_MAX : w_sum[ACC_W-1:0];

    // Response fields are only presented while a total is pending.
    assign resp_valid = w_hold;
    assign resp_id    = w_hold && r_owner;
    assign resp_sum   = w_hold ? r_acc   : '0;
    assign resp_beats = w_hold ? r_beats : '0;
    assign resp_sat   = w_hold && r_sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= 1'b0;
            r_owner  <= 1'b0;
            r_acc    <= '0;
            r_beats  <= '0;
            r_sat    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_grant_id;
                        r_acc   <= ACC_W'(tree_result);
                        r_beats <= BEAT_W'(1);
                        r_sat   <= 1'b0;
                        r_state <= w_sel_last ? S_HOLD : S_BURST;
                    end
                end
                S_BURST: begin
                    if (w_accept) begin
                        r_acc <= w_acc_next;
                        r_sat <= r_sat | w_ovf;
                        if (r_beats != BEAT_MAX) begin
                            r_beats <= r_beats + BEAT_W'(1);
                        end
                        if (w_sel_last) begin
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // Hand priority to the other requester for the next
                    // contended grant, which can happen no earlier than the
                    // cycle after this handshake.
                    if (resp_ready) begin
                        r_state  <= S_IDLE;
                        r_rr_ptr <= ~r_owner;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    a_one_ready: assert property (@(posedge clk) disable iff (rst)
        !(req0_ready && req1_ready));

    a_hold_blocks: assert property (@(posedge clk) disable iff (rst)
        resp_valid |-> (!req0_ready && !req1_ready && tree_data == 32'd0 && tree_mm == 6'd0));

    a_resp_stable: assert property (@(posedge clk) disable iff (rst)
        (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_id) && $stable(resp_sum)
                                         && $stable(resp_beats) && $stable(resp_sat)));

endmodule

// File: tb/tb_adder_tree_arbiter.sv
module tb_adder_tree_arbiter;

    localparam int ACC_W   = 12;
    localparam int BEAT_W  = 8;
    localparam int ACC_MAX = (1 << ACC_W) - 1;
    localparam int BEAT_MAX = (1 << BEAT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req0_ready, req0_last;
    logic [31:0]       req0_data;
    logic [5:0]        req0_mm;
    logic              req1_valid, req1_ready, req1_last;
    logic [31:0]       req1_data;
    logic [5:0]        req1_mm;
    logic [31:0]       tree_data;
    logic [5:0]        tree_mm;
    logic [6:0]        tree_result;
    logic              resp_valid, resp_ready, resp_id, resp_sat;
    logic [ACC_W-1:0]  resp_sum;
    logic [BEAT_W-1:0] resp_beats;

    // Second instance: narrow accumulator and beat counter for clipping.
    logic              s_req0_valid, s_req0_ready, s_req0_last;
    logic [31:0]       s_req0_data;
    logic [5:0]        s_req0_mm;
    logic              s_req1_ready;
    logic [31:0]       s_tree_data;
    logic [5:0]        s_tree_mm;
    logic [6:0]        s_tree_result;
    logic              s_resp_valid, s_resp_id, s_resp_sat;
    logic [6:0]        s_resp_sum;
    logic [1:0]        s_resp_beats;

    typedef struct {
        int sum;
        int beats;
        bit sat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   qid[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   rr_mode;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External tree model: lanes 0..5 gated by the mask, lanes 6..7 always on.
    function automatic logic [6:0] tree_fn(input logic [31:0] d, input logic [5:0] m);
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            if (i >= 6 || m[i]) s += int'(d[i*4 +: 4]);
        end
        return 7'(s);
    endfunction

    assign tree_result   = tree_fn(tree_data, tree_mm);
    assign s_tree_result = tree_fn(s_tree_data, s_tree_mm);

    // Lane data whose full-mask tree sum is exactly v (v <= 120).
    function automatic logic [31:0] make_data(input int v);
        logic [31:0] d;
        int rem;
        int lane;
        d   = '0;
        rem = v;
        for (int i = 0; i < 8; i++) begin
            lane = (rem > 15) ? 15 : rem;
            d[i*4 +: 4] = 4'(lane);
            rem -= lane;
        end
        return d;
    endfunction

    function automatic exp_t mk_exp(input int total, input int n);
        exp_t e;
        e.sum   = (total > ACC_MAX) ? ACC_MAX : total;
        e.beats = (n > BEAT_MAX) ? BEAT_MAX : n;
        e.sat   = (total > ACC_MAX);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int r, input logic v, input logic [31:0] d,
                         input logic [5:0] m, input logic l);
        if (r == 0) begin
            req0_valid = v; req0_data = d; req0_mm = m; req0_last = l;
        end else begin
            req1_valid = v; req1_data = d; req1_mm = m; req1_last = l;
        end
    endtask

    function automatic logic rdy(input int r);
        return (r == 0) ? req0_ready : req1_ready;
    endfunction

    // Sends an n-beat burst; beat b carries value v + b*step (v < 0: random
    // data and mask). Called and returns on a falling edge. The expected
    // total is pushed just before the final beat's accepting edge.
    task automatic send_burst(input int r, input int n, input int v, input int step,
                              input int smin, input int smax);
        int          total;
        int          budget;
        int          st;
        logic [31:0] d;
        logic [5:0]  m;
        logic        a;
        total = 0;
        for (int b = 0; b < n; b++) begin
            if (b > 0) begin
                st = int'($urandom_range(smax, smin));
                if (st > 0) begin
                    drive(r, 1'b0, 32'd0, 6'd0, 1'b0);
                    repeat (st) @(negedge clk);
                end
            end
            if (v < 0) begin
                d = $urandom;
                m = 6'($urandom);
            end else begin
                d = make_data(v + b * step);
                m = 6'h3F;
            end
            total += int'(tree_fn(d, m));
            drive(r, 1'b1, d, m, 1'(b == n - 1));
            budget = 0;
            forever begin
                #1;
                a = rdy(r);
                if (a && b == n - 1) begin
                    if (r == 0) q0.push_back(mk_exp(total, n));
                    else        q1.push_back(mk_exp(total, n));
                end
                @(negedge clk);
                if (a) break;
                budget++;
                if (budget > 3000) begin
                    check("req_accept_timeout", 32'd1, 32'd0);
                    break;
                end
            end
        end
        drive(r, 1'b0, 32'd0, 6'd0, 1'b0);
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while ((q0.size() + q1.size() + qid.size()) != 0 && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        check("drain_timeout", 32'(budget >= 3000), 32'd0);
        @(negedge clk);
    endtask

    // Narrow instance: one requester, consumer always ready.
    task automatic burst7(input int n, input int v);
        int budget;
        int total;
        int e_sum;
        int e_beats;
        logic a;
        total = n * v;
        for (int b = 0; b < n; b++) begin
            s_req0_valid = 1'b1;
            s_req0_data  = make_data(v);
            s_req0_mm    = 6'h3F;
            s_req0_last  = 1'(b == n - 1);
            budget = 0;
            forever begin
                #1;
                a = s_req0_ready;
                @(negedge clk);
                if (a) break;
                budget++;
                if (budget > 100) begin
                    check("n7_accept_timeout", 32'd1, 32'd0);
                    break;
                end
            end
        end
        s_req0_valid = 1'b0;
        s_req0_last  = 1'b0;
        #1;
        e_sum   = (total > 127) ? 127 : total;
        e_beats = (n > 3) ? 3 : n;
        check("n7_resp_valid", 32'(s_resp_valid), 32'd1);
        check("n7_resp_sum",   32'(s_resp_sum),   32'(e_sum));
        check("n7_resp_sat",   32'(s_resp_sat),   32'(total > 127));
        check("n7_resp_beats", 32'(s_resp_beats), 32'(e_beats));
        check("n7_resp_id",    32'(s_resp_id),    32'd0);
        @(negedge clk);
    endtask

    adder_tree_arbiter #(.ACC_W(ACC_W), .BEAT_W(BEAT_W)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_data   (req0_data),
        .req0_mm     (req0_mm),
        .req0_last   (req0_last),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_data   (req1_data),
        .req1_mm     (req1_mm),
        .req1_last   (req1_last),
        .tree_data   (tree_data),
        .tree_mm     (tree_mm),
        .tree_result (tree_result),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_sum    (resp_sum),
        .resp_beats  (resp_beats),
        .resp_sat    (resp_sat)
    );

    adder_tree_arbiter #(.ACC_W(7), .BEAT_W(2)) u_dut7 (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (s_req0_valid),
        .req0_ready  (s_req0_ready),
        .req0_data   (s_req0_data),
        .req0_mm     (s_req0_mm),
        .req0_last   (s_req0_last),
        .req1_valid  (1'b0),
        .req1_ready  (s_req1_ready),
        .req1_data   (32'd0),
        .req1_mm     (6'd0),
        .req1_last   (1'b0),
        .tree_data   (s_tree_data),
        .tree_mm     (s_tree_mm),
        .tree_result (s_tree_result),
        .resp_valid  (s_resp_valid),
        .resp_ready  (1'b1),
        .resp_id     (s_resp_id),
        .resp_sum    (s_resp_sum),
        .resp_beats  (s_resp_beats),
        .resp_sat    (s_resp_sat)
    );

    // Consumer: random backpressure in mode 0, otherwise main drives it.
    initial begin : consumer
        forever begin
            @(negedge clk);
            if (rr_mode == 0) resp_ready = ($urandom_range(3, 0) != 0);
        end
    end

    // Monitor: pops the scoreboard on each response handshake and checks
    // that a stalled response does not change.
    initial begin : monitor
        exp_t              e;
        logic              held;
        logic              p_id, p_sat;
        logic [ACC_W-1:0]  p_sum;
        logic [BEAT_W-1:0] p_beats;
        held = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst || !resp_valid) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_stable_id",    32'(resp_id),    32'(p_id));
                    check("hold_stable_sum",   32'(resp_sum),   32'(p_sum));
                    check("hold_stable_beats", 32'(resp_beats), 32'(p_beats));
                    check("hold_stable_sat",   32'(resp_sat),   32'(p_sat));
                end
                if (resp_ready) begin
                    held = 1'b0;
                    if (qid.size() > 0) check("resp_order_id", 32'(resp_id), qid.pop_front());
                    if ((resp_id ? q1.size() : q0.size()) == 0) begin
                        check("unexpected_resp_for_id", 32'(resp_id), 32'hFFFF_FFFF);
                    end else begin
                        e = resp_id ? q1.pop_front() : q0.pop_front();
                        check("resp_sum",   32'(resp_sum),   32'(e.sum));
                        check("resp_beats", 32'(resp_beats), 32'(e.beats));
                        check("resp_sat",   32'(resp_sat),   32'(e.sat));
                    end
                end else begin
                    held    = 1'b1;
                    p_id    = resp_id;
                    p_sum   = resp_sum;
                    p_beats = resp_beats;
                    p_sat   = resp_sat;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        int c0;
        rr_mode    = 1;
        resp_ready = 1'b1;
        rst        = 1'b1;
        // Valids high during reset must not leak through.
        drive(0, 1'b1, 32'hFFFF_FFFF, 6'h3F, 1'b1);
        drive(1, 1'b1, 32'h1234_5678, 6'h15, 1'b0);
        s_req0_valid = 1'b1; s_req0_data = 32'hFFFF_FFFF; s_req0_mm = 6'h3F; s_req0_last = 1'b1;
        #2;
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        check("rst_tree_data",  tree_data,       32'd0);
        check("rst_tree_mm",    32'(tree_mm),    32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_id",    32'(resp_id),    32'd0);
        check("rst_resp_sum",   32'(resp_sum),   32'd0);
        check("rst_resp_beats", 32'(resp_beats), 32'd0);
        check("rst_resp_sat",   32'(resp_sat),   32'd0);
        check("rst_n7_ready",   32'(s_req0_ready), 32'd0);
        check("rst_n7_tree",    s_tree_data,     32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b0, 32'd0, 6'd0, 1'b0);
        drive(1, 1'b0, 32'd0, 6'd0, 1'b0);
        s_req0_valid = 1'b0; s_req0_last = 1'b0;

        // Single beat of 45: accepted in its first cycle, response next cycle.
        c0 = cyc;
        send_burst(0, 1, 45, 0, 0, 0);
        check("single_accept_cycles", 32'(cyc - c0), 32'd1);
        #1;
        check("single_lat_valid", 32'(resp_valid), 32'd1);
        check("single_lat_id",    32'(resp_id),    32'd0);
        check("single_lat_sum",   32'(resp_sum),   32'd45);
        check("single_lat_beats", 32'(resp_beats), 32'd1);
        wait_drain();

        // Fresh reset, then both contend: ids alternate starting with 0.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            qid.push_back(0);
            qid.push_back(1);
        end
        fork
            begin repeat (5) send_burst(0, 1, 10, 0, 0, 0); end
            begin repeat (5) send_burst(1, 1, 20, 0, 0, 0); end
        join
        wait_drain();

        // req1 owns a 3-beat burst with 2-cycle stalls; req0 waits.
        fork
            begin
                send_burst(1, 3, 30, 10, 2, 2);
            end
            begin
                @(negedge clk);
                drive(0, 1'b1, make_data(7), 6'h3F, 1'b1);
                for (int i = 0; i < 7; i++) begin
                    #1;
                    check("nonowner_ready", 32'(req0_ready), 32'd0);
                    @(negedge clk);
                end
                send_burst(0, 1, 7, 0, 0, 0);
            end
        join
        wait_drain();

        // Long burst clips the 12-bit total.
        send_burst(0, 40, 120, 0, 0, 1);
        wait_drain();

        // Consumer stalls for 5 cycles in HOLD while the other side waits.
        resp_ready = 1'b0;
        rr_mode    = 2;
        fork
            begin
                send_burst(0, 1, 99, 0, 0, 0);
                for (int i = 0; i < 5; i++) begin
                    #1;
                    check("hold_req0_ready", 32'(req0_ready), 32'd0);
                    check("hold_req1_ready", 32'(req1_ready), 32'd0);
                    @(negedge clk);
                end
                resp_ready = 1'b1;
                rr_mode    = 1;
            end
            begin
                @(negedge clk);
                send_burst(1, 1, 5, 0, 0, 0);
            end
        join
        wait_drain();

        // Randomized traffic with random consumer backpressure.
        rr_mode = 0;
        fork
            begin
                repeat (12) begin
                    repeat ($urandom_range(3, 0)) @(negedge clk);
                    send_burst(0, int'($urandom_range(4, 1)), -1, 0, 0, 2);
                end
            end
            begin
                repeat (12) begin
                    repeat ($urandom_range(3, 0)) @(negedge clk);
                    send_burst(1, int'($urandom_range(4, 1)), -1, 0, 0, 2);
                end
            end
        join
        wait_drain();
        rr_mode    = 1;
        resp_ready = 1'b1;
        @(negedge clk);

        // Reset during the second beat of a burst: discarded, no response.
        drive(1, 1'b1, make_data(30), 6'h3F, 1'b0);
        #1;
        check("pre_rst_req1_ready", 32'(req1_ready), 32'd1);
        @(negedge clk);
        drive(1, 1'b1, make_data(40), 6'h3F, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_req1_ready", 32'(req1_ready), 32'd0);
        check("midrst_tree_data",  tree_data,       32'd0);
        check("midrst_tree_mm",    32'(tree_mm),    32'd0);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_resp_sum",   32'(resp_sum),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1'b0, 32'd0, 6'd0, 1'b0);
        fork
            send_burst(0, 1, 11, 0, 0, 0);
            send_burst(1, 1, 22, 0, 0, 0);
            begin
                #1;
                check("postrst_req0_ready", 32'(req0_ready), 32'd1);
                check("postrst_req1_ready", 32'(req1_ready), 32'd0);
            end
        join
        wait_drain();

        // Narrow instance: 7-bit total and 2-bit beat count clip.
        burst7(3, 120);
        burst7(5, 120);
        burst7(3, 40);
        burst7(2, 60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
